// File: rtl/hq_sel_pkg.sv
// Shared definitions for the Hq best-matrix selector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hq_sel_pkg;

    localparam int SAMPLE_W = 16;
    localparam int MW       = 2 * SAMPLE_W + 4;
    localparam int ADDR_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2,
        DONE    = 2'd3
    } sel_state_t;

endpackage

// File: rtl/hq_best_selector_c_pow.sv
// Power of one complex sample: |a|^2 = r*r + i*i, full precision.
// Latency: combinational.
// Backpressure: none.
//
// Ports: a_r/a_i signed sample in, pow unsigned 2N+1-bit power out.
module c_pow #(
    parameter int N = 16
) (
    input  logic signed [N-1:0] a_r,
    input  logic signed [N-1:0] a_i,
    output logic [2*N:0]        pow
);

    logic signed [2*N-1:0] rr;
    logic signed [2*N-1:0] ii;

    // Squares are never negative, so the products can be zero-extended.
    assign rr  = (2*N)'(a_r) * (2*N)'(a_r);
    assign ii  = (2*N)'(a_i) * (2*N)'(a_i);
    assign pow = {1'b0, rr} + {1'b0, ii};

endmodule

// File: rtl/hq_best_selector.sv
// Collects NUM_Q Hq matrices, keeps the one with the largest Frobenius power.
// Latency: element accumulate 1 cycle; best_* update 2 cycles after a matrix ends.
// Backpressure: none, elements are always accepted while a run is active.
//
// Ports: start arms a run; hq_valid/hq_r/hq_i/hq_one_matrix_done/hq_all_done
// carry the producer stream; busy/sel_valid/best_q/best_metric/proto_err report
// the result; rd_en/rd_addr -> rd_valid/rd_r/rd_i read the winning matrix.
module hq_best_selector
    import hq_sel_pkg::*;
#(
    parameter int Q     = 8,
    parameter int N     = 16,
    parameter int NUM_Q = 16,
    parameter int ELEMS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                hq_valid,
    input  logic signed [N-1:0] hq_r,
    input  logic signed [N-1:0] hq_i,
    input  logic                hq_one_matrix_done,
    input  logic                hq_all_done,
    output logic                busy,
    output logic                sel_valid,
    output logic [3:0]          best_q,
    output logic [2*N+3:0]      best_metric,
    output logic                proto_err,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic                rd_valid,
    output logic signed [N-1:0] rd_r,
    output logic signed [N-1:0] rd_i
);

    localparam int MWL = 2 * N + 4;
    localparam int PW  = 2 * N + 1;
    localparam int ECW = $clog2(ELEMS + 1);
    localparam int QW  = $clog2(NUM_Q + 1);

    sel_state_t state, state_nxt;

    logic [MWL-1:0] acc;
    logic [MWL-1:0] cand;
    logic [MWL-1:0] acc_sum;
    logic [3:0]     cand_q;
    logic [ECW-1:0] elem_cnt;
    logic [QW-1:0]  q_cnt;
    logic           first_pend;
    logic [PW-1:0]  pow;

    logic signed [N-1:0] work_r [ELEMS];
    logic signed [N-1:0] work_i [ELEMS];
    logic signed [N-1:0] best_r [ELEMS];
    logic signed [N-1:0] best_i [ELEMS];

    logic in_run, start_ok, elem_take, elem_done, elem_full, elem_acc, elem_drop;
    logic cand_better, finish;

    c_pow #(.N(N)) u_pow (
        .a_r (hq_r),
        .a_i (hq_i),
        .pow (pow)
    );

    assign in_run      = (state == COLLECT) || (state == COMMIT);
    assign start_ok    = ((state == IDLE) || (state == DONE)) && start;
    assign elem_take   = in_run && hq_valid;
    assign elem_done   = elem_take && hq_one_matrix_done;
    assign elem_full   = (elem_cnt == ECW'(ELEMS));
    // A done-flagged element always closes the matrix, even past the 8th slot.
    assign elem_acc    = elem_take && (!elem_full || hq_one_matrix_done);
    assign elem_drop   = elem_take && elem_full && !hq_one_matrix_done;
    assign acc_sum     = acc + MWL'(pow);
    assign cand_better = first_pend || (cand > best_metric);
    // all_done is only honoured in COLLECT, and a closing element takes priority
    // so the final matrix still gets its COMMIT cycle.
    assign finish      = (state == COLLECT) && !elem_done && hq_all_done;
    assign busy        = in_run;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = COLLECT;
            COLLECT: begin
                if (elem_done)        state_nxt = COMMIT;
                else if (hq_all_done) state_nxt = DONE;
            end
            COMMIT:  if (!elem_done) state_nxt = COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            cand        <= '0;
            cand_q      <= '0;
            elem_cnt    <= '0;
            q_cnt       <= '0;
            first_pend  <= 1'b0;
            best_q      <= '0;
            best_metric <= '0;
            proto_err   <= 1'b0;
            sel_valid   <= 1'b0;
            rd_valid    <= 1'b0;
            rd_r        <= '0;
            rd_i        <= '0;
            for (int k = 0; k < ELEMS; k++) begin
                work_r[k] <= '0;
                work_i[k] <= '0;
                best_r[k] <= '0;
                best_i[k] <= '0;
            end
        end else begin
            sel_valid <= 1'b0;

            if (start_ok) begin
                acc        <= '0;
                elem_cnt   <= '0;
                q_cnt      <= '0;
                first_pend <= 1'b1;
                proto_err  <= 1'b0;
            end

            if (elem_acc) begin
                if (!elem_full) begin
                    work_r[elem_cnt[ADDR_W-1:0]] <= hq_r;
                    work_i[elem_cnt[ADDR_W-1:0]] <= hq_i;
                end
                if (hq_one_matrix_done) begin
                    cand     <= acc_sum;
                    cand_q   <= 4'(q_cnt);
                    acc      <= '0;
                    elem_cnt <= '0;
                    q_cnt    <= q_cnt + 1'b1;
                    if (elem_cnt != ECW'(ELEMS - 1)) proto_err <= 1'b1;
                end else begin
                    acc      <= acc_sum;
                    elem_cnt <= elem_cnt + 1'b1;
                end
            end

            if (elem_drop) proto_err <= 1'b1;

            // Strict compare keeps the lower q on ties. The copy reads work_buf
            // before this edge's write, so an element landing in the COMMIT
            // cycle does not leak into the committed matrix.
            if (state == COMMIT) begin
                first_pend <= 1'b0;
                if (cand_better) begin
                    best_metric <= cand;
                    best_q      <= cand_q;
                    for (int k = 0; k < ELEMS; k++) begin
                        best_r[k] <= work_r[k];
                        best_i[k] <= work_i[k];
                    end
                end
            end

            if (finish) begin
                sel_valid <= 1'b1;
                if (q_cnt != QW'(NUM_Q)) proto_err <= 1'b1;
                if (q_cnt == '0) begin
                    best_q      <= '0;
                    best_metric <= '0;
                end
            end

            rd_valid <= rd_en;
            if (rd_en) begin
                rd_r <= best_r[rd_addr];
                rd_i <= best_i[rd_addr];
            end
        end
    end

    // Fraction bits must leave at least the sign bit in the sample word.
    always @(posedge clk) begin
        assert (Q < N);
    end

endmodule

// File: doc/hq_best_selector.md
# hq_best_selector

Consumer end of the precoded-channel stream produced by `matrix_multiplier`. It collects each 4x2 complex Hq matrix (8 elements, row-major, i then j) for all 16 codebook indices q. For each matrix it accumulates the Frobenius power sum(|h|^2), then selects the q with the largest power. It holds that winning matrix in a readable buffer for the downstream detector/feedback stage.

## Interface
Parameters:
- `Q`, 8: fractional bits of input samples (informational; metric is kept in Q(2Q)).
- `N`, 16: input sample width (signed).
- `NUM_Q`, 16: matrices per run.
- `ELEMS`, 8: elements per matrix (4 rows x 2 cols).

Ports (reset `rst`, asynchronous, active-high; clock `clk`):
- `clk` in 1: clock.
- `rst` in 1: async active-high reset.
- `start` in 1: arms a new run. Sampled in IDLE or DONE.
- `hq_valid` in 1: element strobe (`Hq_out_valid` of producer).
- `hq_r`, `hq_i` in N each: signed element.
- `hq_one_matrix_done` in 1: high with the 8th element of a matrix.
- `hq_all_done` in 1: producer finished all matrices (level).
- `busy` out 1: high in COLLECT/COMMIT.
- `sel_valid` out 1: one-cycle pulse when results are final.
- `best_q` out 4: winning index.
- `best_metric` out 2N+4: winning power, unsigned.
- `proto_err` out 1: sticky protocol error, cleared by `start`.
- `rd_en` in 1, `rd_addr` in 3 (=2*i+j): best-buffer read request.
- `rd_valid` out 1, `rd_r`, `rd_i` out N: read response.

## Operation
- States: IDLE, COLLECT, COMMIT, DONE.
- IDLE/DONE + `start`: clear elem_cnt, q_cnt, acc, first-flag, `proto_err` → COLLECT. `start` is ignored in COLLECT/COMMIT.
- Elements are accepted in COLLECT and COMMIT. Each accepted element is written to work_buf[elem_cnt].
  - p = r*r + i*i, full precision, 2N+1 bits unsigned.
  - acc += p, 2N+4 bits, never truncated or saturated.
- Accepted element with `hq_one_matrix_done`:
  - cand ← acc+p, cand_q ← q_cnt.
  - acc ← 0, elem_cnt ← 0, q_cnt ← q_cnt+1.
  - → COMMIT.
  - If elem_cnt≠7 at that point, set `proto_err` (matrix is still committed).
- COMMIT (1 cycle): if first matrix or cand > best_metric (strict), then best_metric ← cand, best_q ← cand_q, best_buf ← work_buf. → COLLECT. Ties keep the lower q.
- 9th element without done flag: set `proto_err`, element dropped, acc unchanged.
- `hq_all_done` in COLLECT → DONE, `sel_valid` pulses. If q_cnt≠NUM_Q, set `proto_err`. If q_cnt==0, results are best_q=0, best_metric=0.
- `hq_all_done` during COMMIT is honoured on the following COLLECT cycle.
- Reads are legal in any state and return the current best_buf[rd_addr].

## Timing
- Reset: all outputs 0, state IDLE, buffers 0.
- Element acceptance: 1-cycle (registered acc).
- COMMIT decision is visible on `best_*` 2 cycles after the done-flagged element.
- An element arriving in the COMMIT cycle is accepted into work_buf[0] and the copy uses the pre-edge contents. Arbitrary spacing ≥1 cycle is supported.
- `sel_valid`: registered pulse in the first DONE cycle. `best_*` hold stable until the next `start`.
- Read latency 1 cycle: `rd_valid` = `rd_en` delayed 1; `rd_r`/`rd_i` registered.
- Reset mid-run aborts immediately. No pulse of `sel_valid`.

## Structure
- Package `hq_sel_pkg`: state enum, localparam MW = 2*N+4, ADDR_W = 3.
- Sub-module `c_pow` (|a|^2 of one complex sample, 2N+1 bits). It is shared by the accumulate path and the test bench model.
- Two 8-entry register files (work_buf, best_buf) inside the top.

## Test plan
- All elements 0 except q=5, every element r=0x0100, i=0: best_q=5, best_metric=0x80000, `sel_valid` single pulse, `proto_err`=0.
- Sixteen identical matrices (r=i=0x0080): best_q=0 (tie rule), best_metric=8*2*0x4000=0x40000.
- After the run, read addr 0..7 with q=9 winning (element k = r=k*0x10, i=−k*0x10): `rd_r`/`rd_i` match 1 cycle after each `rd_en`.
- Done flag on the 6th element of q=2: `proto_err`=1, q_cnt advances, run still completes with `sel_valid`.
- Element strobed in the COMMIT cycle (back-to-back valids across a matrix boundary): both matrices' metrics correct.
- Assert `rst` midway through q=7: all outputs 0, state IDLE. A fresh `start` run then produces correct results.
